// File: rtl/vga_timing_if.sv
// Video timing bundle between the timing generator and the renderer/VGA output stages.
// The generator side takes pix_en in and drives sync, strobes, coordinates and frame count out.
interface vga_timing_if #(
    parameter int unsigned CW  = 11,
    parameter int unsigned FCW = 8
);
    logic           pix_en;
    logic           hsync;
    logic           vsync;
    logic           data_enable;
    logic           frame;
    logic           line;
    logic [CW-1:0]  x;
    logic [CW-1:0]  y;
    logic [FCW-1:0] frame_cnt;

    modport master (
        input  pix_en,
        output hsync, vsync, data_enable, frame, line, x, y, frame_cnt
    );

    modport slave (
        output pix_en,
        input  hsync, vsync, data_enable, frame, line, x, y, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator with pixel-clock enable, selectable sync polarity,
// registered coordinates, line/frame strobes and a wrapping completed-frame counter.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned CW       = 11,
    parameter int unsigned FCW      = 8
) (
    input logic         clk,
    input logic         rst,
    vga_timing_if.master vid
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_zero_width
        $error("vga_timing_gen: every porch, sync and active width must be non-zero");
    end
    if (((H_TOTAL - 1) >> CW) != 0 || ((V_TOTAL - 1) >> CW) != 0) begin : g_cw_too_small
        $error("vga_timing_gen: CW too narrow for H_TOTAL-1 or V_TOTAL-1");
    end

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_W  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_W  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SS     = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SE     = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SS     = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SE     = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0]  hc_q, hc_d, vc_q, vc_d;
    logic [FCW-1:0] cnt_q, cnt_d;
    logic [CW-1:0]  x_q, y_q;
    logic           de_q, de_d, hs_q, hs_d, vs_q, vs_d, frame_q, frame_d, line_q, line_d;

    always_comb begin
        hc_d  = hc_q + 1'b1;
        vc_d  = vc_q;
        cnt_d = cnt_q;
        if (hc_q == H_LAST) begin
            hc_d = '0;
            if (vc_q == V_LAST) begin
                vc_d  = '0;
                cnt_d = cnt_q + 1'b1;
            end else begin
                vc_d = vc_q + 1'b1;
            end
        end
        // Decode uses the pre-advance counters, so outputs lag the counters by one pixel.
        de_d    = (hc_q < H_ACT_W) && (vc_q < V_ACT_W);
        hs_d    = ((hc_q >= H_SS) && (hc_q < H_SE)) ? H_POL : ~H_POL;
        vs_d    = ((vc_q >= V_SS) && (vc_q < V_SE)) ? V_POL : ~V_POL;
        line_d  = (hc_q == '0);
        frame_d = (hc_q == '0) && (vc_q == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hc_q    <= '0;
            vc_q    <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            de_q    <= 1'b0;
            hs_q    <= ~H_POL;
            vs_q    <= ~V_POL;
            frame_q <= 1'b0;
            line_q  <= 1'b0;
        end else if (vid.pix_en) begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            cnt_q   <= cnt_d;
            x_q     <= hc_q;
            y_q     <= vc_q;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            frame_q <= frame_d;
            line_q  <= line_d;
        end else begin
            frame_q <= 1'b0;
            line_q  <= 1'b0;
        end
    end

    assign vid.x           = x_q;
    assign vid.y           = y_q;
    assign vid.data_enable = de_q;
    assign vid.hsync       = hs_q;
    assign vid.vsync       = vs_q;
    assign vid.frame       = frame_q;
    assign vid.line        = line_q;
    assign vid.frame_cnt   = cnt_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen: two small-mode instances (active-low, and active-high with
// a 2-bit frame counter) checked every clock against a pixel-index reference model.
module tb_vga_timing_gen;
    localparam int HA = 8, HF = 2, HS = 3, HB = 1;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vga_timing_if #(.CW(11), .FCW(8)) va ();
    vga_timing_if #(.CW(11), .FCW(2)) vb ();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b0), .V_POL(1'b0), .CW(11), .FCW(8)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .vid (va)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b1), .V_POL(1'b1), .CW(11), .FCW(2)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .vid (vb)
    );

    int n_checks = 0;
    int n_errors = 0;
    // Model state: enabled edges since reset release, and whether the last edge was enabled.
    int k = 0;
    bit strobe = 1'b0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (k=%0d, t=%0t)", tag, got, exp, k, $time);
        end
    endtask

    task automatic check_dut(input string nm, input bit pol, input int fcw,
                             input logic [10:0] ox, input logic [10:0] oy, input logic ode,
                             input logic ohs, input logic ovs, input logic ofr,
                             input logic oln, input int ocnt);
        int p, ex, ey, ecnt;
        bit ede, ehs, evs, efr, eln;
        if (k == 0) begin
            ex = 0; ey = 0; ede = 0; ehs = ~pol; evs = ~pol; efr = 0; eln = 0; ecnt = 0;
        end else begin
            p    = (k - 1) % FT;
            ex   = p % HT;
            ey   = p / HT;
            ede  = (ex < HA) && (ey < VA);
            ehs  = (ex >= HA + HF && ex < HA + HF + HS) ? pol : ~pol;
            evs  = (ey >= VA + VF && ey < VA + VF + VS) ? pol : ~pol;
            efr  = strobe && (p == 0);
            eln  = strobe && (ex == 0);
            ecnt = (k / FT) % (1 << fcw);
        end
        check({nm, ".x"}, ox, ex);
        check({nm, ".y"}, oy, ey);
        check({nm, ".de"}, ode, ede);
        check({nm, ".hsync"}, ohs, ehs);
        check({nm, ".vsync"}, ovs, evs);
        check({nm, ".frame"}, ofr, efr);
        check({nm, ".line"}, oln, eln);
        check({nm, ".frame_cnt"}, ocnt, ecnt);
    endtask

    task automatic step(input bit en, input bit rs);
        rst       = rs;
        va.pix_en = en;
        vb.pix_en = en;
        @(posedge clk);
        if (!rs) begin
            k = 0;
            strobe = 1'b0;
        end else if (en) begin
            k++;
            strobe = 1'b1;
        end else begin
            strobe = 1'b0;
        end
        @(negedge clk);
        check_dut("a", 1'b0, 8, va.x, va.y, va.data_enable, va.hsync, va.vsync,
                  va.frame, va.line, int'(va.frame_cnt));
        check_dut("b", 1'b1, 2, vb.x, vb.y, vb.data_enable, vb.hsync, vb.vsync,
                  vb.frame, vb.line, int'(vb.frame_cnt));
    endtask

    initial begin
        va.pix_en = 1'b1;
        vb.pix_en = 1'b1;
        @(negedge clk);

        // Reset for 3 clocks, then one line and two full frames at full rate.
        repeat (3) step(1'b1, 1'b0);
        repeat (HT + 2 * FT) step(1'b1, 1'b1);
        check("s3_cnt_after_2_frames", va.frame_cnt, 2);

        // Half-rate pixel clock from a fresh reset: one frame takes 2*FT clocks.
        step(1'b1, 1'b0);
        for (int i = 0; i < 2 * FT; i++) step((i % 2) == 0, 1'b1);
        check("s4_cnt_half_rate", va.frame_cnt, 1);

        // Mid-frame reset when the outputs show x=5, y=2.
        for (int i = 0; i < FT && !(k > 0 && ((k - 1) % FT) == 2 * HT + 5); i++)
            step(1'b1, 1'b1);
        check("s5_reached_x5", va.x, 5);
        check("s5_reached_y2", va.y, 2);
        step(1'b1, 1'b0);
        check("s5_cnt_cleared", va.frame_cnt, 0);
        step(1'b1, 1'b1);
        check("s5_frame_after_reset", va.frame, 1);

        // Four full frames from reset: 2-bit counter wraps 3 -> 0.
        step(1'b1, 1'b0);
        repeat (4 * FT) step(1'b1, 1'b1);
        check("s6_cnt_wrap_b", vb.frame_cnt, 0);
        check("s6_cnt_a", va.frame_cnt, 4);

        // Random pix_en with occasional resets.
        for (int i = 0; i < 3000; i++)
            step(($urandom % 4) != 0, ($urandom % 300) != 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised video timing generator: the next generation of the team's fixed-mode VGA timing block.
- Porch, sync and active widths are set per instance; sync polarity is selectable.
- A pixel-clock enable lets the block run from a faster system clock.
- Exports registered pixel coordinates, line and frame strobes, and a frame counter to the sprite/renderer and VGA output stages.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync asserted level (0 = active-low)
- V_POL, 0, vsync asserted level (0 = active-low)
- CW, 11, coordinate/counter width
- FCW, 8, frame counter width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- pix_en  in  1  pixel strobe; timing advances only when high
- hsync  out  1  horizontal sync, polarity per H_POL
- vsync  out  1  vertical sync, polarity per V_POL
- data_enable  out  1  high inside the active area
- frame  out  1  one-clk pulse at the first pixel of each frame
- line  out  1  one-clk pulse at the first pixel of each line
- x  out  CW  horizontal position (0..H_TOTAL-1)
- y  out  CW  vertical position (0..V_TOTAL-1)
- frame_cnt  out  FCW  completed-frame count, wraps

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Elaboration error if H_TOTAL-1 or V_TOTAL-1 does not fit in CW bits, or if any width parameter is 0.
- Internal counters hc and vc, both unsigned CW bits.
- Reset: sampled on posedge clk while rst==0.
  - hc=0, vc=0, frame_cnt=0.
  - Outputs: x=0, y=0, data_enable=0, frame=0, line=0, hsync=~H_POL, vsync=~V_POL (deasserted).
- Advance, on a posedge with pix_en=1:
  - If hc==H_TOTAL-1: hc<=0. Then if vc==V_TOTAL-1, vc<=0 and frame_cnt<=frame_cnt+1 (mod 2^FCW); otherwise vc<=vc+1.
  - Otherwise hc<=hc+1.
- Output decode, registered on the same edge from the pre-advance hc/vc (latency one enabled cycle):
  - x<=hc, y<=vc
  - data_enable <= (hc<H_ACTIVE) && (vc<V_ACTIVE)
  - hsync <= H_POL when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, else ~H_POL
  - vsync <= V_POL when V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, else ~V_POL; vsync transitions occur only at hc==0 boundaries
  - line <= (hc==0); frame <= (hc==0 && vc==0)
- pix_en=0 edges:
  - Counters, frame_cnt, x, y, hsync, vsync and data_enable hold.
  - frame and line are forced to 0, so each strobe lasts exactly one clk per occurrence.
- Consequences:
  - The first enabled edge after reset release produces frame=1, line=1, data_enable=1, x=0, y=0.
  - frame_cnt increments on the same edge that produces the last pixel of the frame (x=H_TOTAL-1, y=V_TOTAL-1). It is therefore visible together with the following frame pulse.
- Reset asserted mid-frame: takes effect on that edge regardless of pix_en. No partial-frame increment of frame_cnt.
- Simultaneous line and frame wrap: both strobes assert on the same edge.
- pix_en tied high: one pixel per clk; identical to the fixed-mode block's cadence.

Test Plan:
- Small mode for scenarios 1-4: H 8/2/3/1 (H_TOTAL=14), V 4/1/2/1 (V_TOTAL=8), pix_en=1.
  1. Hold rst=0 for 3 clk, then release -> during reset: hsync=vsync=1, data_enable=0, frame=0. First edge after release: frame=1, line=1, x=0, y=0, data_enable=1.
  2. Run one line -> data_enable high for x=0..7; hsync low exactly for x=10,11,12; line pulses once every 14 clk.
  3. Run 2 full frames -> frame pulses exactly 112 clk apart. vsync low for y=5,6 (28 clk, starting at x=0). frame_cnt 0->1->2, each increment on the x=13,y=7 edge.
  4. pix_en toggling 1,0 -> period doubles; frame pulse width stays 1 clk. x/y/hsync hold on disabled clk; frame_cnt reaches 1 after 224 clk.
- Remaining scenarios:
  5. Mid-frame reset: pull rst=0 at x=5,y=2 for 1 clk -> outputs return to reset values. frame_cnt=0. Next enabled edge gives frame=1, x=0, y=0.
  6. H_POL=1, V_POL=1, FCW=2 -> hsync/vsync are high-true and idle low. frame_cnt wraps 3->0 on the 4th frame end.
